// File: rtl/uart_cfg_frame_ctrl_if.sv
// Byte-in / register-write-out bus between the UART receiver, the frame
// controller and the lidar configuration register bank.
interface uart_cfg_frame_ctrl_if;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        cfg_ready;
  logic        cfg_wr_en;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        busy;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  modport master (
    output rx_byte, rx_byte_valid, cfg_ready,
    input  cfg_wr_en, cfg_addr, cfg_wdata, busy, frame_ok_cnt, frame_err_cnt
  );

  modport slave (
    input  rx_byte, rx_byte_valid, cfg_ready,
    output cfg_wr_en, cfg_addr, cfg_wdata, busy, frame_ok_cnt, frame_err_cnt
  );
endinterface

// File: rtl/uart_cfg_frame_ctrl.sv
// Framed UART command decoder: HEADER, ADDR, D3..D0, XOR CSUM -> one
// ready/valid register write, with inter-byte timeout and status counters.
module uart_cfg_frame_ctrl #(
  parameter logic [7:0]  HEADER      = 8'h5A,
  parameter int unsigned TIMEOUT_CYC = 40000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_cfg_frame_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_WRITE} state_t;

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic [7:0]  addr_sh_q;
  logic [31:0] shadow_q;
  logic [19:0] tmo_q;
  logic        wr_en_q, busy_q;
  logic [7:0]  cfg_addr_q;
  logic [31:0] cfg_wdata_q;
  logic [15:0] ok_cnt_q, err_cnt_q;

  logic       byte_v, in_frame, tmo_hit, hs, err_ev, load_wr;
  logic [7:0] csum_calc;

  assign byte_v    = bus.rx_byte_valid;
  assign in_frame  = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  // A byte in the expiry cycle wins over the timeout.
  assign tmo_hit   = in_frame && !byte_v && (tmo_q == TMO_LAST);
  assign hs        = wr_en_q && bus.cfg_ready;
  assign csum_calc = addr_sh_q ^ shadow_q[31:24] ^ shadow_q[23:16] ^
                     shadow_q[15:8] ^ shadow_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_ev  = 1'b0;
    load_wr = 1'b0;
    if (tmo_hit) begin
      state_d = S_IDLE;
      err_ev  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:  if (byte_v && bus.rx_byte == HEADER) state_d = S_ADDR;
        S_ADDR:  if (byte_v) state_d = S_DATA;
        S_DATA:  if (byte_v && idx_q == 2'd3) state_d = S_CSUM;
        S_CSUM: begin
          if (byte_v) begin
            if (bus.rx_byte == csum_calc) begin
              state_d = S_WRITE;
              load_wr = 1'b1;
            end else begin
              state_d = S_IDLE;
              err_ev  = 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Bytes during a pending write are overruns; handshake still completes.
          if (byte_v) err_ev = 1'b1;
          if (hs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      addr_sh_q   <= '0;
      shadow_q    <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (!in_frame || byte_v || tmo_hit) tmo_q <= '0;
      else                                tmo_q <= tmo_q + 20'd1;

      if (state_q == S_ADDR && byte_v) begin
        addr_sh_q <= bus.rx_byte;
        idx_q     <= '0;
      end
      if (state_q == S_DATA && byte_v) begin
        shadow_q <= {shadow_q[23:0], bus.rx_byte};
        idx_q    <= idx_q + 2'd1;
      end

      if (load_wr) begin
        cfg_addr_q  <= addr_sh_q;
        cfg_wdata_q <= shadow_q;
      end
      wr_en_q <= (state_d == S_WRITE);
      busy_q  <= (state_d != S_IDLE);

      if (hs && ok_cnt_q != 16'hFFFF)      ok_cnt_q  <= ok_cnt_q + 16'd1;
      if (err_ev && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.cfg_wr_en     = wr_en_q;
  assign bus.cfg_addr      = cfg_addr_q;
  assign bus.cfg_wdata     = cfg_wdata_q;
  assign bus.busy          = busy_q;
  assign bus.frame_ok_cnt  = ok_cnt_q;
  assign bus.frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_cfg_frame_ctrl.sv
// Directed bench for uart_cfg_frame_ctrl with a write scoreboard.
module tb_uart_cfg_frame_ctrl;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  wr_t  exp_q[$];

  uart_cfg_frame_ctrl_if bus();

  uart_cfg_frame_ctrl #(.HEADER(8'h5A), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte       = b;
    bus.rx_byte_valid = 1'b1;
    tick();
    bus.rx_byte_valid = 1'b0;
  endtask

  function automatic logic [7:0] csum(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit push);
    send(8'h5A);
    send(a);
    send(d[31:24]);
    send(d[23:16]);
    send(d[15:8]);
    send(d[7:0]);
    if (push) exp_q.push_back('{addr: a, data: d});
    send(csum(a, d));
  endtask

  // Scoreboard: every handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && bus.cfg_wr_en && bus.cfg_ready) begin
      wr_t e;
      writes++;
      chk("sb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_addr", 32'(bus.cfg_addr), 32'(e.addr));
        chk("sb_wdata", bus.cfg_wdata, e.data);
      end
    end
  end

  initial begin
    int w0;
    rst_n             = 1'b0;
    bus.cfg_ready     = 1'b1;
    bus.rx_byte_valid = 1'b0;
    bus.rx_byte       = 8'h00;
    repeat (3) tick();
    chk("rst_wr_en", 32'(bus.cfg_wr_en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_addr", 32'(bus.cfg_addr), 32'd0);
    chk("rst_wdata", bus.cfg_wdata, 32'd0);
    chk("rst_ok", 32'(bus.frame_ok_cnt), 32'd0);
    chk("rst_err", 32'(bus.frame_err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Good frame, ready already high: single-cycle write pulse
    send(8'h5A);
    chk("busy_after_hdr", 32'(bus.busy), 32'd1);
    send(8'h03); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    exp_q.push_back('{addr: 8'h03, data: 32'h12345678});
    send(8'h0B);
    chk("good_wr_en", 32'(bus.cfg_wr_en), 32'd1);
    chk("good_addr", 32'(bus.cfg_addr), 32'h03);
    chk("good_wdata", bus.cfg_wdata, 32'h12345678);
    tick();
    chk("good_wr_fall", 32'(bus.cfg_wr_en), 32'd0);
    chk("good_ok", 32'(bus.frame_ok_cnt), 32'd1);
    chk("good_busy", 32'(bus.busy), 32'd0);

    // Bad checksum then an immediate good frame
    send(8'h5A); send(8'h03); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h0C);
    chk("bad_wr_en", 32'(bus.cfg_wr_en), 32'd0);
    chk("bad_err", 32'(bus.frame_err_cnt), 32'd1);
    chk("bad_busy", 32'(bus.busy), 32'd0);
    send_frame(8'h21, 32'hDEADBEEF, 1'b1);
    tick();
    chk("after_bad_ok", 32'(bus.frame_ok_cnt), 32'd2);

    // Timeout: 16 idle cycles after the last byte
    send(8'h5A); send(8'h03); send(8'h12);
    repeat (15) tick();
    chk("tmo_not_yet_busy", 32'(bus.busy), 32'd1);
    chk("tmo_not_yet_err", 32'(bus.frame_err_cnt), 32'd1);
    tick();
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    chk("tmo_err", 32'(bus.frame_err_cnt), 32'd2);
    send(8'h34);
    chk("tmo_stray_busy", 32'(bus.busy), 32'd0);
    chk("tmo_stray_err", 32'(bus.frame_err_cnt), 32'd2);

    // Byte sampled on the expiry edge wins
    send(8'h5A); send(8'h03); send(8'h12);
    repeat (15) tick();
    send(8'h34);
    chk("edge_busy", 32'(bus.busy), 32'd1);
    chk("edge_err", 32'(bus.frame_err_cnt), 32'd2);
    send(8'h56); send(8'h78);
    exp_q.push_back('{addr: 8'h03, data: 32'h12345678});
    send(8'h0B);
    tick();
    chk("edge_ok", 32'(bus.frame_ok_cnt), 32'd3);

    // Backpressure with a stray byte injected while the write is pending
    bus.cfg_ready = 1'b0;
    w0 = writes;
    send_frame(8'h44, 32'hCAFEF00D, 1'b1);
    for (int i = 0; i < 50; i++) begin
      chk("bp_wr_en", 32'(bus.cfg_wr_en), 32'd1);
      chk("bp_addr", 32'(bus.cfg_addr), 32'h44);
      chk("bp_wdata", bus.cfg_wdata, 32'hCAFEF00D);
      bus.rx_byte       = 8'h99;
      bus.rx_byte_valid = (i == 20);
      tick();
    end
    bus.rx_byte_valid = 1'b0;
    chk("bp_overrun_err", 32'(bus.frame_err_cnt), 32'd3);
    bus.cfg_ready = 1'b1;
    tick();
    chk("bp_wr_fall", 32'(bus.cfg_wr_en), 32'd0);
    chk("bp_ok", 32'(bus.frame_ok_cnt), 32'd4);
    chk("bp_single_write", 32'(writes - w0), 32'd1);

    // Garbage, then header bytes used as payload
    send(8'h00); send(8'hFF); send(8'h11);
    chk("noise_busy", 32'(bus.busy), 32'd0);
    send_frame(8'h5A, 32'h5A5A5A5A, 1'b1);
    chk("hip_addr", 32'(bus.cfg_addr), 32'h5A);
    chk("hip_wdata", bus.cfg_wdata, 32'h5A5A5A5A);
    tick();
    chk("hip_ok", 32'(bus.frame_ok_cnt), 32'd5);
    chk("hip_err", 32'(bus.frame_err_cnt), 32'd3);

    // Reset after D2 loses the partial frame
    send(8'h5A); send(8'h03); send(8'h12); send(8'h34);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ok", 32'(bus.frame_ok_cnt), 32'd0);
    chk("mid_rst_err", 32'(bus.frame_err_cnt), 32'd0);
    chk("mid_rst_addr", 32'(bus.cfg_addr), 32'd0);
    chk("mid_rst_wdata", bus.cfg_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h03, 32'h12345678, 1'b1);
    tick();
    chk("post_rst_ok", 32'(bus.frame_ok_cnt), 32'd1);
    chk("post_rst_err", 32'(bus.frame_err_cnt), 32'd0);

    // Reset during WRITE drops cfg_wr_en without a clock edge
    bus.cfg_ready = 1'b0;
    send_frame(8'h10, 32'h00000001, 1'b0);
    chk("wr_pending", 32'(bus.cfg_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_wr_drop", 32'(bus.cfg_wr_en), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Saturation: overrun bytes every cycle while the write is held off
    send_frame(8'h77, 32'h01020304, 1'b1);
    bus.rx_byte       = 8'h00;
    bus.rx_byte_valid = 1'b1;
    repeat (65534) tick();
    chk("sat_below", 32'(bus.frame_err_cnt), 32'hFFFE);
    repeat (6) tick();
    bus.rx_byte_valid = 1'b0;
    chk("sat_err", 32'(bus.frame_err_cnt), 32'hFFFF);
    chk("sat_wr_held", 32'(bus.cfg_wr_en), 32'd1);
    bus.cfg_ready = 1'b1;
    tick();
    chk("sat_ok", 32'(bus.frame_ok_cnt), 32'd1);
    chk("sat_err_hold", 32'(bus.frame_err_cnt), 32'hFFFF);

    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
